// File: rtl/alu_nibble_serial_addsub.sv
// 32-bit adder/subtractor using one 4-bit slice, one nibble per clock, LSB nibble first.
// Operands and partial sum live in internal shift registers; res/flags change only on completion.

module alu_nibble_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       co
);
    logic [3:0] lo;
    logic [1:0] hi;

    // Split at bit 3 so the carry into the slice MSB is exposed for signed overflow.
    always_comb begin
        lo = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
        c3 = lo[3];
        hi = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, c3};
        s  = {hi[0], lo[2:0]};
        co = hi[1];
    end
endmodule

module alu_nibble_serial_addsub #(
    parameter int NIBBLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   src_a,
    input  logic [4*NIBBLES-1:0]   src_b,
    input  logic                   sub,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   res,
    output logic                   carry,
    output logic                   overflow,
    output logic                   zero
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [W-1:0]   a_sr;
    logic [W-1:0]   b_sr;
    logic [W-1:0]   acc;
    logic           cin;
    logic [CW-1:0]  cnt;

    logic [3:0]     nib_sum;
    logic           nib_c3;
    logic           nib_co;
    logic [W-1:0]   acc_nxt;

    alu_nibble_slice u_slice (
        .a  (a_sr[3:0]),
        .b  (b_sr[3:0]),
        .ci (cin),
        .s  (nib_sum),
        .c3 (nib_c3),
        .co (nib_co)
    );

    // Sum nibbles enter at the top; after NIBBLES shifts the word is in place.
    assign acc_nxt = {nib_sum, acc[W-1:4]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            acc      <= '0;
            cin      <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            res      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= src_a;
                        b_sr  <= sub ? ~src_b : src_b;
                        cin   <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 4;
                    b_sr <= b_sr >> 4;
                    acc  <= acc_nxt;
                    cin  <= nib_co;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(NIBBLES - 1)) begin
                        res      <= acc_nxt;
                        carry    <= nib_co;
                        overflow <= nib_co ^ nib_c3;
                        zero     <= (acc_nxt == '0);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_nibble_serial_addsub.sv
// Directed bench: per-cycle compare against an arithmetic reference model plus literal result checks.

module tb_alu_nibble_serial_addsub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        sub = 1'b0;
    logic        busy, done, carry, overflow, zero;
    logic [31:0] res;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    alu_nibble_serial_addsub #(.NIBBLES(8)) dut (
        .clk(clk), .rst(rst), .start(start), .src_a(src_a), .src_b(src_b), .sub(sub),
        .busy(busy), .done(done), .res(res), .carry(carry), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    // Reference model: an accepted op finishes 8 edges after acceptance.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_res = '0, p_res = '0;
    logic        m_c = 1'b0, m_v = 1'b0, m_z = 1'b0, p_c = 1'b0, p_v = 1'b0;

    always @(posedge clk) begin
        logic [32:0] s;
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_res = '0; m_c = 1'b0; m_v = 1'b0; m_z = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1; m_res = p_res; m_c = p_c; m_v = p_v; m_z = (p_res == 0);
                end
            end else if (start) begin
                if (sub) s = {1'b0, src_a} - {1'b0, src_b};
                else     s = {1'b0, src_a} + {1'b0, src_b};
                p_res = s[31:0];
                p_c   = sub ? (src_a >= src_b) : s[32];
                p_v   = sub ? (src_a[31] != src_b[31] && p_res[31] != src_a[31])
                            : (src_a[31] == src_b[31] && p_res[31] != src_a[31]);
                m_left = 8;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (busy !== (m_left > 0) || done !== m_done || res !== m_res ||
                carry !== m_c || overflow !== m_v || zero !== m_z) begin
                errors++;
                $display("FAIL model t=%0t got busy=%b done=%b res=%h c=%b v=%b z=%b want busy=%b done=%b res=%h c=%b v=%b z=%b",
                         $time, busy, done, res, carry, overflow, zero,
                         (m_left > 0), m_done, m_res, m_c, m_v, m_z);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Caller is at a negedge; start is driven now and accepted at the next posedge.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] er, input logic ec, input logic ev, input logic ez);
        int n = 0;
        start = 1'b1; src_a = a; src_b = b; sub = s;
        do begin
            @(negedge clk);
            start = 1'b0;
            src_a = $urandom; src_b = $urandom; sub = $urandom_range(0, 1);
            n++;
        end while (!done && n < 20);
        chk({name, "_lat"}, 64'(n), 64'd9);
        chk({name, "_res"}, 64'(res), 64'(er));
        chk({name, "_flags"}, 64'({carry, overflow, zero}), 64'({ec, ev, ez}));
    endtask

    initial begin
        int n, dcnt;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_state", 64'({busy, done, res, carry, overflow, zero}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add_small", 32'h00000001, 32'h00000010, 1'b0, 32'h00000011, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        run_op("add_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        run_op("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_op("sub_ovf",   32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        run_op("sub_borrow",32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_equal", 32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);

        // Restart attempt mid-run with churning operands: only one done, first result wins.
        start = 1'b1; src_a = 32'h0000_1234; src_b = 32'h0000_0F0F; sub = 1'b0;
        n = 0; dcnt = 0;
        while (n < 14) begin
            @(negedge clk);
            n++;
            start = (n == 3);
            src_a = $urandom; src_b = $urandom; sub = $urandom_range(0, 1);
            if (done) begin
                dcnt++;
                chk("restart_res", 64'(res), 64'h0000_2143);
                chk("restart_lat", 64'(n), 64'd9);
                break;
            end
        end
        chk("restart_done_seen", 64'(dcnt), 64'd1);
        // Back-to-back from the DONE cycle.
        run_op("b2b", 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("no_extra_done", 64'(dcnt), 64'd0);

        // Reset during RUN at the fourth processing edge.
        start = 1'b1; src_a = 32'h1111_1111; src_b = 32'h2222_2222; sub = 1'b0;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 64'({busy, done, res}), 64'd0);
        rst = 1'b0;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);
        run_op("after_abort", 32'h1111_1111, 32'h2222_2222, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 1'b0);

        // Reset and start together: reset wins, nothing starts.
        @(negedge clk);
        start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        chk("rst_beats_start", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
